// File: rtl/sobel_column_feeder.sv
// rtl/sobel_column_feeder.sv - raster line-buffer feeder and result collector for a 1-2-1 weighting unit
// Builds vertical 3-pixel columns from two line buffers and runs one weighting transaction per pixel from row 2 on.
module sobel_column_feeder #(
    parameter int  BITS  = 8,
    parameter int  WIDTH = 640,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic signed [BITS-1:0]      pix_in,
    input  logic                        pix_sof,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    output logic [2:0][BITS-1:0]        col_pixels,
    output logic                        weight_en,
    input  logic                        weight_done,
    input  logic signed [BITS-1:0]      weight_result,
    output logic signed [BITS-1:0]      res_out,
    output logic [CW-1:0]               res_col,
    output logic                        res_valid
);

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                  r_state;
    logic [BITS-1:0]         r_lb0 [WIDTH];
    logic [BITS-1:0]         r_lb1 [WIDTH];
    logic [CW-1:0]           r_col_cnt;
    logic [1:0]              r_row_cnt;
    logic [CW-1:0]           r_issue_col;
    logic [2:0][BITS-1:0]    r_col_pixels;
    logic                    r_weight_en;
    logic signed [BITS-1:0]  r_res_out;
    logic [CW-1:0]           r_res_col;
    logic                    r_res_valid;

    logic                    w_accept;
    logic [CW-1:0]           w_col;
    logic [1:0]              w_row;
    logic                    w_last_col;

    // SOF restarts the frame at the pixel it qualifies, so counters are overridden before use.
    assign w_accept   = pix_valid && (r_state == S_ACCEPT);
    assign w_col      = pix_sof ? '0 : r_col_cnt;
    assign w_row      = pix_sof ? 2'd0 : r_row_cnt;
    assign w_last_col = (w_col == CW'(WIDTH - 1));

    assign pix_ready  = (r_state == S_ACCEPT);
    assign col_pixels = r_col_pixels;
    assign weight_en  = r_weight_en;
    assign res_out    = r_res_out;
    assign res_col    = r_res_col;
    assign res_valid  = r_res_valid;

    // Line buffers carry no reset; stale contents are overwritten as new rows arrive.
    always_ff @(posedge clk) begin
        if (n_rst && w_accept) begin
            r_lb0[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state      <= S_ACCEPT;
            r_col_cnt    <= '0;
            r_row_cnt    <= 2'd0;
            r_issue_col  <= '0;
            r_col_pixels <= '0;
            r_weight_en  <= 1'b0;
            r_res_out    <= '0;
            r_res_col    <= '0;
            r_res_valid  <= 1'b0;
        end else begin
            r_weight_en <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                S_ACCEPT: begin
                    if (w_accept) begin
                        r_col_pixels <= {pix_in, r_lb1[w_col], r_lb0[w_col]};
                        r_issue_col  <= w_col;
                        r_col_cnt    <= w_last_col ? '0 : w_col + 1'b1;
                        r_row_cnt    <= (w_last_col && (w_row != 2'd2)) ? w_row + 2'd1 : w_row;
                        if (w_row == 2'd2) begin
                            r_state     <= S_ISSUE;
                            r_weight_en <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (weight_done) begin
                        r_res_out   <= weight_result;
                        r_res_col   <= r_issue_col;
                        r_res_valid <= 1'b1;
                        r_state     <= S_ACCEPT;
                    end
                end
                default: begin
                    r_state <= S_ACCEPT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_column_feeder.sv
// tb/tb_sobel_column_feeder.sv - self-checking bench for sobel_column_feeder with a 1-2-1 downstream model
// Frame-level reference model plus table-driven vectors and hand-written corner sequences.
module tb_sobel_column_feeder;

    localparam int BITS  = 8;
    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH);

    logic                 clk;
    logic                 n_rst;
    logic [BITS-1:0]      pix_in;
    logic                 pix_sof;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [2:0][BITS-1:0] col_pixels;
    logic                 weight_en;
    logic                 weight_done;
    logic [BITS-1:0]      weight_result;
    logic [BITS-1:0]      res_out;
    logic [CW-1:0]        res_col;
    logic                 res_valid;

    sobel_column_feeder #(.BITS(BITS), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .pix_in        (pix_in),
        .pix_sof       (pix_sof),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .col_pixels    (col_pixels),
        .weight_en     (weight_en),
        .weight_done   (weight_done),
        .weight_result (weight_result),
        .res_out       (res_out),
        .res_col       (res_col),
        .res_valid     (res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    typedef struct {
        logic [7:0] res;
        int         col;
        logic [7:0] p0, p1, p2;
    } exp_t;

    typedef struct {
        logic [7:0] res;
        int         col;
        int         at;
    } rv_t;

    exp_t       exp_q[$];
    rv_t        rv_log[$];
    logic [7:0] img [0:15][0:3];
    int         m_row = 0;
    int         m_col = 0;
    bit         prev_low = 1'b1;

    // Downstream stand-in: out = p0 + 2*p1 + p2 mod 256, done after ds_stall extra cycles.
    int         ds_stall = 0;
    bit         ds_pending = 1'b0;
    int         ds_wait = 0;
    logic [7:0] ds_res;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        weight_done = 1'b0;
        if (ds_pending) begin
            if (ds_wait == 0) begin
                weight_done   = 1'b1;
                weight_result = ds_res;
                ds_pending    = 1'b0;
            end else begin
                ds_wait--;
            end
        end
        if (weight_en && n_rst) begin
            ds_pending = 1'b1;
            ds_wait    = ds_stall;
            ds_res     = 8'(int'(col_pixels[0]) + 2 * int'(col_pixels[1]) + int'(col_pixels[2]));
        end
    end

    always @(negedge clk) begin
        if (n_rst) begin
            if (weight_en) begin
                if (exp_q.size() == 0) chk("unexpected_weight_en", weight_en, 0);
                else chk("col_pixels", col_pixels, {exp_q[0].p2, exp_q[0].p1, exp_q[0].p0});
            end
            if (res_valid) begin
                rv_t r;
                r.res = res_out; r.col = int'(res_col); r.at = cyc;
                rv_log.push_back(r);
                if (exp_q.size() == 0) chk("unexpected_res_valid", res_valid, 0);
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_out_model", res_out, e.res);
                    chk("res_col_model", res_col, e.col);
                end
            end
        end
    end

    task automatic send(input logic [7:0] v, input bit sof, input int gap);
        int n;
        exp_t e;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        if (sof) begin m_row = 0; m_col = 0; end
        img[m_row][m_col] = v;
        if (m_row >= 2) begin
            e.p0  = img[m_row-2][m_col];
            e.p1  = img[m_row-1][m_col];
            e.p2  = v;
            e.res = 8'(int'(e.p0) + 2 * int'(e.p1) + int'(e.p2));
            e.col = m_col;
            exp_q.push_back(e);
        end
        if (prev_low) chk("ready_low_rows", pix_ready, 1);
        pix_in = v; pix_sof = sof; pix_valid = 1'b1;
        n = 0;
        while (!pix_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("accept_bound", 0, 1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
        prev_low = (m_row < 2);
        m_col++;
        if (m_col == WIDTH) begin m_col = 0; m_row++; end
    endtask

    task automatic send_row(input logic [7:0] v, input bit sof);
        for (int c = 0; c < WIDTH; c++) send(v, sof && (c == 0), 0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        ds_pending = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        exp_q.delete();
        m_row = 0; m_col = 0; prev_low = 1'b1;
    endtask

    typedef struct {
        logic [7:0] r0 [4];
        logic [7:0] r1 [4];
        logic [7:0] r2 [4];
        logic [7:0] expv [4];
        int         stall;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0].r0 = '{8'd1, 8'd1, 8'd1, 8'd1};
        vecs[0].r1 = '{8'd2, 8'd2, 8'd2, 8'd2};
        vecs[0].r2 = '{8'd3, 8'd3, 8'd3, 8'd3};
        vecs[0].expv = '{8'd8, 8'd8, 8'd8, 8'd8};
        vecs[0].stall = 0;
        vecs[1].r0 = '{8'd1, 8'd2, 8'd3, 8'd4};
        vecs[1].r1 = '{8'd10, 8'd20, 8'd30, 8'd40};
        vecs[1].r2 = '{8'd5, 8'd6, 8'd7, 8'd8};
        vecs[1].expv = '{8'd26, 8'd48, 8'd70, 8'd92};
        vecs[1].stall = 0;
        vecs[2].r0 = '{8'd100, 8'd100, 8'd100, 8'd100};
        vecs[2].r1 = '{8'd100, 8'd100, 8'd100, 8'd100};
        vecs[2].r2 = '{8'd0, 8'd0, 8'd0, 8'd0};
        vecs[2].expv = '{8'h2C, 8'h2C, 8'h2C, 8'h2C};
        vecs[2].stall = 0;
        vecs[3].r0 = '{8'hFF, 8'h80, 8'h7F, 8'h00};
        vecs[3].r1 = '{8'hFE, 8'h01, 8'h7F, 8'h00};
        vecs[3].r2 = '{8'd3, 8'h80, 8'h01, 8'hFF};
        vecs[3].expv = '{8'hFE, 8'h02, 8'h7E, 8'hFF};
        vecs[3].stall = 2;

        n_rst = 1'b0; pix_in = '0; pix_sof = 1'b0; pix_valid = 1'b0;
        weight_done = 1'b0; weight_result = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        chk("rst_res_out", res_out, 0);
        chk("rst_res_col", res_col, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_weight_en", weight_en, 0);
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_col_pixels", col_pixels, 0);

        for (int v = 0; v < 4; v++) begin
            ds_stall = vecs[v].stall;
            rv_log.delete();
            for (int c = 0; c < WIDTH; c++) send(vecs[v].r0[c], c == 0, 0);
            for (int c = 0; c < WIDTH; c++) send(vecs[v].r1[c], 1'b0, 0);
            for (int c = 0; c < WIDTH; c++) send(vecs[v].r2[c], 1'b0, 0);
            drain();
            chk("tbl_count", rv_log.size(), 4);
            for (int c = 0; c < rv_log.size() && c < 4; c++) begin
                chk("tbl_res", rv_log[c].res, vecs[v].expv[c]);
                chk("tbl_col", rv_log[c].col, c);
                if (c > 0) chk("tbl_spacing", rv_log[c].at - rv_log[c-1].at, 3 + vecs[v].stall);
            end
        end

        // Stall: downstream holds done low for 5 cycles.
        begin
            logic [2:0][BITS-1:0] saved;
            int en_cnt = 0, unstable = 0, ready_hi = 0;
            bit got = 1'b0, prev_done = 1'b0;
            ds_stall = 5;
            send_row(8'd7, 1'b1);
            send_row(8'd9, 1'b0);
            send(8'd11, 1'b0, 0);
            saved = col_pixels;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (weight_en) en_cnt++;
                if (col_pixels !== saved) unstable++;
                if (res_valid) begin
                    got = 1'b1;
                    chk("stall_rv_after_done", prev_done, 1);
                end else if (pix_ready) ready_hi++;
                prev_done = weight_done;
            end
            chk("stall_result_seen", got, 1);
            chk("stall_en_once", en_cnt, 1);
            chk("stall_col_stable", unstable, 0);
            chk("stall_ready_low", ready_hi, 0);
            drain();
        end

        // Mid-frame SOF at row 3, col 2.
        ds_stall = 1;
        send_row(8'd4, 1'b1);
        send_row(8'd5, 1'b0);
        send_row(8'd6, 1'b0);
        send(8'd20, 1'b0, 0);
        send(8'd21, 1'b0, 0);
        drain();
        rv_log.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < WIDTH; c++)
                send(8'($urandom_range(0, 255)), (r == 0) && (c == 0), 0);
        drain();
        chk("sof_count", rv_log.size(), 4);
        if (rv_log.size() > 0) chk("sof_first_col", rv_log[0].col, 0);

        // Reset while waiting on the downstream unit.
        ds_stall = 10;
        send_row(8'd1, 1'b1);
        send_row(8'd2, 1'b0);
        send(8'd3, 1'b0, 0);
        repeat (2) @(negedge clk);
        do_reset();
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_weight_en", weight_en, 0);
        chk("mid_rst_pix_ready", pix_ready, 1);
        ds_stall = 0;
        rv_log.delete();
        send_row(8'd30, 1'b0);
        send_row(8'd31, 1'b0);
        repeat (4) @(negedge clk);
        chk("mid_rst_no_results", rv_log.size(), 0);
        send_row(8'd32, 1'b0);
        drain();
        chk("mid_rst_row2_count", rv_log.size(), 4);

        // Random frames against the frame model.
        for (int f = 0; f < 6; f++) begin
            int rows;
            ds_stall = $urandom_range(0, 3);
            rows = $urandom_range(3, 6);
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < WIDTH; c++)
                    send(8'($urandom), (r == 0) && (c == 0), $urandom_range(0, 1));
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
